// File: rtl/seq_multiplier_if.sv
// Handshake and operand/result bus between the execute-stage control and the multiplier.
interface seq_multiplier_if;
  localparam int unsigned W = 32;

  logic         start;
  logic         signed_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  // Control unit side: issues requests, observes status and result.
  modport master (
    output start, signed_op, a, b,
    input  busy, done, hi, lo
  );

  // Multiplier side: samples requests, drives status and result.
  modport slave (
    input  start, signed_op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative 32x32 shift-add multiplier (mult/multu) with start/busy/done handshake.
// Signed operands are reduced to magnitudes, multiplied unsigned over 32 RUN
// cycles, and the sign is applied in a single FIX cycle before hi/lo update.
module seq_multiplier (
  input  logic              clk,
  input  logic              reset,
  seq_multiplier_if.slave   bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept_c;
  logic [W-1:0]    mag_a_c;
  logic [W-1:0]    mag_b_c;
  logic [PW-1:0]   result_c;

  // State and datapath registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state, datapath update and registered status decode.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    // A new request is only taken when no operation is in flight.
    accept_c = bus.start && ((state_q == IDLE) || (state_q == DONE));
    // |0x80000000| wraps back to 0x80000000, which is the right unsigned magnitude.
    mag_a_c  = (bus.signed_op && bus.a[W-1]) ? W'(-bus.a) : bus.a;
    mag_b_c  = (bus.signed_op && bus.b[W-1]) ? W'(-bus.b) : bus.b;
    result_c = neg_q ? PW'(-acc_q) : acc_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept_c) begin
          mcand_d  = PW'(mag_a_c);
          mplier_d = mag_b_c;
          neg_d    = bus.signed_op && (bus.a[W-1] ^ bus.b[W-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        // Shifting multiplicand/multiplier: bit 0 of mplier is mag_b[count].
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(W - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        hi_d    = result_c[PW-1:W];
        lo_d    = result_c[W-1:0];
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed cases plus random operands
// compared against a plain-arithmetic 64-bit product model.
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_multiplier_if mif ();

  seq_multiplier dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference product: exact mult/multu result modulo 2^64.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    longint sa;
    longint sb;
    logic [63:0] ua;
    logic [63:0] ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request at the negedge so it is sampled at the next rising edge (E0).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    mif.start     = 1'b1;
    mif.signed_op = s;
    mif.a         = a;
    mif.b         = b;
    @(posedge clk);
    #1;
    mif.start     = 1'b0;
    mif.a         = $urandom;
    mif.b         = $urandom;
    mif.signed_op = 1'($urandom);
  endtask

  // Called #1 after E0: count edges to done and cycles with busy high.
  task automatic wait_done(output int lat, output int busy_cyc);
    lat      = 0;
    busy_cyc = mif.busy ? 1 : 0;
    while (mif.done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (mif.busy === 1'b1 && mif.done !== 1'b1) busy_cyc++;
      if (mif.busy === 1'b1 && mif.done === 1'b1) check("busy_and_done", 1, 0);
    end
  endtask

  task automatic full_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input bit chk_lat);
    int lat;
    int bc;
    issue(a, b, s);
    wait_done(lat, bc);
    if (chk_lat) begin
      check({tag, "_lat"}, 64'(lat), 64'd33);
      check({tag, "_busy"}, 64'(bc), 64'd33);
    end
    check(tag, {mif.hi, mif.lo}, ref_prod(a, b, s));
  endtask

  initial begin
    int lat;
    int bc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [63:0] held;

    mif.start     = 1'b0;
    mif.signed_op = 1'b0;
    mif.a         = '0;
    mif.b         = '0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(mif.busy), 64'd0);
    check("rst_done", 64'(mif.done), 64'd0);
    check("rst_hilo", {mif.hi, mif.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases with explicit expected values.
    full_op("multu_7x6", 32'd7, 32'd6, 1'b0, 1'b1);
    check("multu_7x6_const", {mif.hi, mif.lo}, 64'h0000_0000_0000_002A);
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(mif.done), 64'd0);
    full_op("mult_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
    check("mult_m3x5_const", {mif.hi, mif.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    full_op("multu_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_ffxff_const", {mif.hi, mif.lo}, 64'hFFFF_FFFE_0000_0001);
    full_op("mult_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("mult_ffxff_const", {mif.hi, mif.lo}, 64'h0000_0000_0000_0001);
    full_op("mult_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    check("mult_min_const", {mif.hi, mif.lo}, 64'h4000_0000_0000_0000);
    full_op("mult_zero", 32'd0, 32'h8000_0000, 1'b1, 1'b0);
    full_op("mult_min_x1", 32'h8000_0000, 32'd1, 1'b1, 1'b0);
    check("mult_min_x1_const", {mif.hi, mif.lo}, 64'hFFFF_FFFF_8000_0000);

    // hi/lo hold through IDLE and through a following RUN; mid-RUN start ignored.
    full_op("hold_setup", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
    held = {mif.hi, mif.lo};
    repeat (3) @(posedge clk);
    #1;
    check("hold_idle", {mif.hi, mif.lo}, held);
    issue(32'd1000, 32'd1000, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("hold_run", {mif.hi, mif.lo}, held);
    @(negedge clk);
    mif.start = 1'b1;
    mif.a     = 32'd55;
    mif.b     = 32'd77;
    @(negedge clk);
    mif.start = 1'b0;
    wait_done(lat, bc);
    check("ignore_start_lat", 64'(lat + 6), 64'd33);
    check("ignore_start", {mif.hi, mif.lo}, 64'd1_000_000);

    // Back-to-back: start held in DONE launches the next op with no IDLE cycle.
    full_op("b2b_first", 32'd9, 32'd11, 1'b0, 1'b0);
    mif.start     = 1'b1;
    mif.signed_op = 1'b1;
    mif.a         = 32'hFFFF_FF00;
    mif.b         = 32'd300;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    check("b2b_busy_now", 64'(mif.busy), 64'd1);
    check("b2b_done_low", 64'(mif.done), 64'd0);
    wait_done(lat, bc);
    check("b2b_spacing", 64'(lat + 1), 64'd34);
    check("b2b_second", {mif.hi, mif.lo}, ref_prod(32'hFFFF_FF00, 32'd300, 1'b1));

    // Asynchronous reset at RUN count=10.
    issue(32'd123, 32'd456, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", 64'(mif.busy), 64'd0);
    check("arst_done", 64'(mif.done), 64'd0);
    check("arst_hilo", {mif.hi, mif.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("arst_no_done", 64'(mif.done), 64'd0);
    full_op("after_rst", 32'd3, 32'd4, 1'b0, 1'b1);
    check("after_rst_const", {mif.hi, mif.lo}, 64'd12);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom);
      if (i % 6 == 0) ra = {ra[31], 31'd0};
      if (i % 8 == 1) rb = 32'hFFFF_FFFF;
      full_op($sformatf("rand%0d", i), ra, rb, rs, (i % 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
